// File: rtl/usr_op_sequencer.sv
// Command-driven sequencer for the 4-bit universal shift register: optional parallel
// load, N cycles of one select code, then capture of the register output as a response.
module usr_op_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] usr_data,
  output logic [2:0]       select,
  output logic [WIDTH-1:0] parallel_in,
  output logic             busy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data
);

  // state   | meaning
  // IDLE    | waiting for a command, register untouched
  // LOAD    | one cycle of parallel load with the latched data
  // OP      | latched select code applied once per cycle, counter running down
  // CAPTURE | register settled, sample it into rsp_data
  // RESP    | response held until the consumer takes it
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_OP      = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [2:0]       SEL_HOLD = 3'b000;
  localparam logic [2:0]       SEL_LOAD = 3'b111;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_load)            state_nxt = S_LOAD;
          else if (cmd_count != '0) state_nxt = S_OP;
          else                     state_nxt = S_CAPTURE;
        end
      end
      S_LOAD:    state_nxt = (cnt_q != '0) ? S_OP : S_CAPTURE;
      S_OP:      state_nxt = (cnt_q == CNT_ONE) ? S_CAPTURE : S_OP;
      S_CAPTURE: state_nxt = S_RESP;
      S_RESP:    state_nxt = rsp_ready ? S_IDLE : S_RESP;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Command fields are only written in IDLE so stray commands cannot disturb a transaction.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      op_q     <= SEL_HOLD;
      cnt_q    <= '0;
      data_q   <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            cnt_q  <= cmd_count;
            data_q <= cmd_data;
          end
        end
        S_OP:      cnt_q    <= cnt_q - CNT_ONE;
        S_CAPTURE: rsp_data <= usr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    select    = SEL_HOLD;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_LOAD:  select    = SEL_LOAD;
      S_OP:    select    = op_q;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign parallel_in = data_q;

endmodule

// File: tb/tb_usr_op_sequencer.sv
// Bench for usr_op_sequencer: a behavioural shift register sits downstream, and a
// transaction-level model predicts every cycle's outputs and each response value.
module tb_usr_op_sequencer;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [2:0] cmd_count = 3'd0;
  logic       cmd_load = 1'b0;
  logic [3:0] cmd_data = 4'd0;
  logic [3:0] usr_q;
  logic [2:0] select;
  logic [3:0] parallel_in;
  logic       busy;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;

  usr_op_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_load(cmd_load), .cmd_data(cmd_data),
    .usr_data(usr_q), .select(select), .parallel_in(parallel_in),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // Downstream universal shift register; serial inputs of the X shifts tied high.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) usr_q <= 4'd0;
    else begin
      case (select)
        3'd0: usr_q <= usr_q;
        3'd1: usr_q <= {1'b0, usr_q[3:1]};
        3'd2: usr_q <= {usr_q[2:0], 1'b0};
        3'd3: usr_q <= {usr_q[0], usr_q[3:1]};
        3'd4: usr_q <= {usr_q[2:0], usr_q[3]};
        3'd5: usr_q <= {1'b1, usr_q[3:1]};
        3'd6: usr_q <= {usr_q[2:0], 1'b1};
        default: usr_q <= parallel_in;
      endcase
    end
  end

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Register value after an optional load and n applications of op, in plain arithmetic.
  function automatic logic [3:0] model(input logic [3:0] cur, input bit l,
                                       input logic [3:0] d, input logic [2:0] op, input int n);
    int r;
    r = l ? int'(d) : int'(cur);
    for (int i = 0; i < n; i++) begin
      case (op)
        3'd1: r = r / 2;
        3'd2: r = (r * 2) % 16;
        3'd3: r = r / 2 + (r % 2) * 8;
        3'd4: r = (r * 2) % 16 + r / 8;
        3'd5: r = r / 2 + 8;
        3'd6: r = (r * 2) % 16 + 1;
        3'd7: r = int'(d);
        default: r = r;
      endcase
    end
    return 4'(r);
  endfunction

  logic [2:0] e_sel = 3'd0;
  logic       e_ready = 1'b1, e_busy = 1'b0, e_valid = 1'b0;
  logic [3:0] e_rdata = 4'd0, e_pin = 4'd0;
  bit         pin_en = 1'b0, chk_en = 1'b0;
  logic [3:0] exp_reg = 4'd0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("select", 8'(select), 8'(e_sel));
      chk("cmd_ready", 8'(cmd_ready), 8'(e_ready));
      chk("busy", 8'(busy), 8'(e_busy));
      chk("rsp_valid", 8'(rsp_valid), 8'(e_valid));
      chk("rsp_data", 8'(rsp_data), 8'(e_rdata));
      if (pin_en) chk("parallel_in", 8'(parallel_in), 8'(e_pin));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_sel = 3'd0; e_ready = 1'b1; e_busy = 1'b0; e_valid = 1'b0; pin_en = 1'b0;
  endtask

  task automatic set_busy(input logic [2:0] s, input bit pe);
    e_sel = s; e_ready = 1'b0; e_busy = 1'b1; e_valid = 1'b0; pin_en = pe;
  endtask

  task automatic run_cmd(input bit l, input logic [3:0] d, input logic [2:0] op,
                         input int n, input int hold, input bit extra, input int lit);
    logic [3:0] res;
    int         nl;
    res = model(exp_reg, l, d, op, n);
    nl  = l ? 1 : 0;
    set_idle();
    cmd_valid = 1'b1; cmd_load = l; cmd_data = d; cmd_op = op; cmd_count = 3'(n);
    step();
    cmd_valid = 1'b0; cmd_load = ~l; cmd_data = ~d; cmd_op = ~op; cmd_count = ~3'(n);
    e_pin = d;
    for (int j = 0; j < nl + n; j++) begin
      set_busy((j < nl) ? 3'd7 : op, 1'b1);
      step();
    end
    set_busy(3'd0, 1'b0);
    step();
    e_valid = 1'b1; e_rdata = res;
    if (lit >= 0) begin
      #2;
      chk("rsp_literal", 8'(rsp_data), 8'(lit));
    end
    rsp_ready = 1'b0;
    cmd_valid = extra;
    repeat (hold) step();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    set_idle();
    exp_reg = res;
  endtask

  initial begin
    #1 clear = 1'b0;
    #1;
    chk("rst_select", 8'(select), 8'd0);
    chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("rst_rsp_data", 8'(rsp_data), 8'd0);
    chk("rst_cmd_ready", 8'(cmd_ready), 8'd1);
    chk("rst_busy", 8'(busy), 8'd0);
    repeat (2) @(posedge clk);
    #1 clear = 1'b1;
    set_idle();
    chk_en = 1'b1;
    step();

    run_cmd(1'b1, 4'b1011, 3'd0, 0, 0, 1'b0, 11);
    chk("usr_holds_load", 8'(usr_q), 8'd11);
    run_cmd(1'b1, 4'b1111, 3'd1, 4, 0, 1'b0, 0);
    run_cmd(1'b1, 4'b1111, 3'd2, 4, 0, 1'b0, 0);
    run_cmd(1'b1, 4'b1000, 3'd3, 1, 0, 1'b0, 4);
    run_cmd(1'b1, 4'b1000, 3'd4, 1, 0, 1'b0, 1);
    run_cmd(1'b1, 4'b0011, 3'd2, 0, 0, 1'b0, 3);
    run_cmd(1'b0, 4'b0000, 3'd2, 2, 0, 1'b0, 12);
    run_cmd(1'b1, 4'b1001, 3'd4, 3, 5, 1'b1, 12);
    run_cmd(1'b0, 4'b0000, 3'd0, 0, 0, 1'b0, 12);
    run_cmd(1'b1, 4'b0110, 3'd7, 2, 1, 1'b0, 6);
    run_cmd(1'b0, 4'b0000, 3'd1, 7, 0, 1'b0, 0);
    run_cmd(1'b1, 4'b0001, 3'd6, 2, 0, 1'b0, -1);

    // Reset asserted mid-cycle while a count-7 operation is running.
    set_idle();
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_data = 4'b0101; cmd_op = 3'd3; cmd_count = 3'd7;
    step();
    cmd_valid = 1'b0;
    e_pin = 4'b0101;
    set_busy(3'd7, 1'b1);
    step();
    set_busy(3'd3, 1'b1);
    step();
    step();
    #2 clear = 1'b0;
    set_idle();
    e_rdata = 4'd0; e_pin = 4'd0; pin_en = 1'b1;
    #1;
    chk("midop_select", 8'(select), 8'd0);
    chk("midop_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("midop_rsp_data", 8'(rsp_data), 8'd0);
    chk("midop_cmd_ready", 8'(cmd_ready), 8'd1);
    chk("midop_busy", 8'(busy), 8'd0);
    step();
    clear = 1'b1;
    pin_en = 1'b0;
    exp_reg = 4'd0;
    repeat (8) step();
    run_cmd(1'b0, 4'b0000, 3'd0, 0, 0, 1'b0, 0);
    step();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/usr_op_sequencer.md
Name: usr_op_sequencer

Overview:
Command-driven controller that sits directly upstream of the 4-bit universal shift register and drives its select and parallel_in inputs. It accepts one command over a valid/ready handshake: an optional parallel load, then N cycles of one shift/rotate/hold operation. It then samples the register's data output and returns it over a valid/ready response channel. This turns multi-cycle register manipulation into single transactions for the rest of the datapath.

Parameters:
WIDTH, 4, data width; must match the shift register width.
CNT_W, 3, width of the repeat count; maximum repeat is 2^CNT_W-1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
clear  input  1  asynchronous, active-low reset; the same net that clears the shift register.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command.
cmd_op  input  3  select code to apply during the operation phase (000 hold, 001 SHR0, 010 SHL0, 011 ROR, 100 ROL, 101 SHR-X, 110 SHL-X, 111 load).
cmd_count  input  CNT_W  number of operation cycles (0..2^CNT_W-1).
cmd_load  input  1  precede the operation with a parallel load of cmd_data.
cmd_data  input  WIDTH  value to load.
usr_data  input  WIDTH  shift register data output.
select  output  3  shift register select.
parallel_in  output  WIDTH  shift register parallel input.
busy  output  1  high in any state other than IDLE.
rsp_valid  output  1  response available.
rsp_ready  input  1  response consumer ready.
rsp_data  output  WIDTH  captured register value.

Behaviour:
- Reset (clear=0, asynchronous): state IDLE, latched command and down-counter cleared, select=000, parallel_in=0, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=1. Takes effect mid-transaction with no completion; any partial response is discarded.
- Moore outputs decoded from registered state and latched fields only; no combinational path from cmd_* or rsp_ready to select or parallel_in.
- States: IDLE, LOAD, OP, CAPTURE, RESP.
- IDLE:
  - cmd_ready=1 and select=000.
  - On cmd_valid=1 at an edge, latch op, count, load and data.
  - Next state is LOAD if load=1, else OP if count>0, else CAPTURE.
- LOAD: exactly one cycle. select=111, parallel_in=latched data. Next state is OP if count>0, else CAPTURE.
- OP:
  - select=latched op and parallel_in=latched data on every cycle.
  - The counter decrements at each edge.
  - After exactly count edges in OP, go to CAPTURE.
  - op=111 repeats the load; op=000 holds for count cycles.
- CAPTURE: one cycle, select=000. At the edge, rsp_data<=usr_data (the post-operation value) and the state moves to RESP.
- RESP:
  - rsp_valid=1, select=000.
  - rsp_data stays stable until rsp_valid&rsp_ready at an edge, then the state returns to IDLE.
  - rsp_valid deasserts in the cycle after the handshake.
- cmd_ready=0 in every non-IDLE state. cmd_valid outside IDLE is ignored and does not overwrite latched fields.
- RESP with rsp_ready=1 and cmd_valid=1 in the same cycle: the response completes, and the command is accepted at the following IDLE edge (one bubble cycle).
- Latency: rsp_valid rises L+N+1 edges after the accept edge, where L=cmd_load (0/1) and N=cmd_count. Minimum latency is 1 edge (no load, count 0: captures the current register contents).
- Counter: CNT_W bits, no wrap. count=0 never enters OP.
- Exactly one register-modifying edge per LOAD/OP cycle; the register is never modified in IDLE, CAPTURE or RESP.

Test Plan:
- Reset, with clear pulsed low mid-cycle → immediately select=000, rsp_valid=0, rsp_data=0000, cmd_ready=1, busy=0.
- cmd load=1 data=1011 op=000 count=0 → rsp_valid 2 edges after accept, rsp_data=1011, register holds 1011.
- load=1 data=1111 op=001 count=4 → rsp_valid after 6 edges, rsp_data=0000; the same with op=010 also gives 0000.
- load=1 data=1000 op=011 count=1 → rsp_data=0100; load=1 data=1000 op=100 count=1 → rsp_data=0001.
- load=1 data=0011 op=010 count=0, then load=0 op=010 count=2 → second rsp_data=1100 (no-load path preserves register contents).
- Two response and reset checks:
  - Hold rsp_ready=0 for 5 cycles with cmd_valid=1 → rsp_valid held, rsp_data stable, cmd_ready=0, and the extra command is ignored.
  - Assert clear=0 during OP with count=7 → IDLE with all outputs at their reset values, and no response is issued.
